// File: rtl/axi_mem_bank.sv
// Multi-port AXI subordinate sharing one 64-bit word array; single-beat transfers, round-robin write commit.
// Build option: define AXI_MEM_BANK_WSTRB_EN to make w.strb gate byte lanes (default: full-word writes).

package axi_pkg;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
    } axi_r_t;
endpackage

module axi_mem_bank_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic             push;

    assign push  = push_valid && push_ready;
    assign head  = slots[rd_ptr];
    assign empty = (count == '0);

    always_comb begin
        // NOTE: assigning the default first keeps every path defined, so no latch is inferred.
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nxt;
            push_ready <= (count_nxt != FULL_CNT);
        end
    end

    // NOTE: storage has no reset; count alone decides which slots hold valid entries.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_data;
    end
endmodule

module axi_mem_bank
    import axi_pkg::*;
#(
    parameter int PORT_NB     = 4,
    parameter int WORD_NB     = 4096,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  axi_aw_t i_axi_s_aw      [PORT_NB],
    input  logic    i_axi_s_awvalid [PORT_NB],
    output logic    o_axi_s_awready [PORT_NB],
    input  axi_w_t  i_axi_s_w       [PORT_NB],
    input  logic    i_axi_s_wvalid  [PORT_NB],
    output logic    o_axi_s_wready  [PORT_NB],
    output axi_b_t  o_axi_s_b       [PORT_NB],
    output logic    o_axi_s_bvalid  [PORT_NB],
    input  logic    i_axi_s_bready  [PORT_NB],
    input  axi_ar_t i_axi_s_ar      [PORT_NB],
    input  logic    i_axi_s_arvalid [PORT_NB],
    output logic    o_axi_s_arready [PORT_NB],
    output axi_r_t  o_axi_s_r       [PORT_NB],
    output logic    o_axi_s_rvalid  [PORT_NB],
    input  logic    i_axi_s_rready  [PORT_NB]
);
    localparam int PW = (PORT_NB > 1) ? $clog2(PORT_NB) : 1;
    localparam int IW = (WORD_NB > 1) ? $clog2(WORD_NB) : 1;
    localparam logic [AXI_ADDR_W-1:0] WORD_LIMIT = AXI_ADDR_W'(WORD_NB);

    logic [AXI_DATA_W-1:0] mem [WORD_NB];

    axi_aw_t            aw_head [PORT_NB];
    axi_w_t             w_head  [PORT_NB];
    axi_ar_t            ar_head [PORT_NB];
    logic [PORT_NB-1:0] aw_empty, w_empty, ar_empty;
    logic [PORT_NB-1:0] wr_req, wr_pop, rd_issue;

    logic          grant_valid;
    logic [PW-1:0] grant_idx, rr_ptr, cand;
    axi_aw_t       gnt_aw;
    axi_w_t        gnt_w;

    function automatic logic addr_ok(input logic [AXI_ADDR_W-1:0] addr);
        return (addr >> 3) < WORD_LIMIT;
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AXI_ADDR_W-1:0] addr);
        return IW'(addr >> 3);
    endfunction

    for (genvar p = 0; p < PORT_NB; p++) begin : g_port
        axi_mem_bank_fifo #(.WIDTH($bits(axi_aw_t)), .DEPTH(QUEUE_DEPTH)) u_aw_fifo (
            .clk(clk), .rst(rst),
            .push_valid(i_axi_s_awvalid[p]), .push_ready(o_axi_s_awready[p]),
            .push_data(i_axi_s_aw[p]), .pop(wr_pop[p]),
            .head(aw_head[p]), .empty(aw_empty[p])
        );

        axi_mem_bank_fifo #(.WIDTH($bits(axi_w_t)), .DEPTH(QUEUE_DEPTH)) u_w_fifo (
            .clk(clk), .rst(rst),
            .push_valid(i_axi_s_wvalid[p]), .push_ready(o_axi_s_wready[p]),
            .push_data(i_axi_s_w[p]), .pop(wr_pop[p]),
            .head(w_head[p]), .empty(w_empty[p])
        );

        axi_mem_bank_fifo #(.WIDTH($bits(axi_ar_t)), .DEPTH(QUEUE_DEPTH)) u_ar_fifo (
            .clk(clk), .rst(rst),
            .push_valid(i_axi_s_arvalid[p]), .push_ready(o_axi_s_arready[p]),
            .push_data(i_axi_s_ar[p]), .pop(rd_issue[p]),
            .head(ar_head[p]), .empty(ar_empty[p])
        );

        // A response slot counts as free when it is empty or being drained at this edge.
        assign wr_req[p]   = !aw_empty[p] && !w_empty[p] && (!o_axi_s_bvalid[p] || i_axi_s_bready[p]);
        assign wr_pop[p]   = grant_valid && (grant_idx == PW'(p));
        assign rd_issue[p] = !ar_empty[p] && (!o_axi_s_rvalid[p] || i_axi_s_rready[p]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o_axi_s_bvalid[p] <= 1'b0;
                o_axi_s_b[p]      <= '0;
            end else if (wr_pop[p]) begin
                o_axi_s_bvalid[p] <= 1'b1;
                o_axi_s_b[p]      <= axi_b_t'{id:   gnt_aw.id,
                                              resp: addr_ok(gnt_aw.addr) ? AXI_RESP_OKAY : AXI_RESP_DECERR};
            end else if (i_axi_s_bready[p]) begin
                o_axi_s_bvalid[p] <= 1'b0;
            end
        end

        // The read samples mem before this edge's write lands, giving pre-write data on collisions.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o_axi_s_rvalid[p] <= 1'b0;
                o_axi_s_r[p]      <= '0;
            end else if (rd_issue[p]) begin
                o_axi_s_rvalid[p] <= 1'b1;
                o_axi_s_r[p]      <= axi_r_t'{id:   ar_head[p].id,
                                              data: addr_ok(ar_head[p].addr) ? mem[word_idx(ar_head[p].addr)] : '0,
                                              resp: addr_ok(ar_head[p].addr) ? AXI_RESP_OKAY : AXI_RESP_DECERR};
            end else if (i_axi_s_rready[p]) begin
                o_axi_s_rvalid[p] <= 1'b0;
            end
        end
    end

    // Round-robin search starts at rr_ptr and takes the first requester found.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < PORT_NB; k++) begin
            cand = PW'((int'(rr_ptr) + k) % PORT_NB);
            if (!grant_valid && wr_req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign gnt_aw = aw_head[grant_idx];
    assign gnt_w  = w_head[grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (int'(grant_idx) == PORT_NB - 1) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef AXI_MEM_BANK_WSTRB_EN
    always_ff @(posedge clk) begin
        if (grant_valid && addr_ok(gnt_aw.addr)) begin
            for (int i = 0; i < AXI_DATA_W / 8; i++) begin
                if (gnt_w.strb[i]) mem[word_idx(gnt_aw.addr)][i*8 +: 8] <= gnt_w.data[i*8 +: 8];
            end
        end
    end
`else
    // Byte strobes are carried through the W queue but have no effect in this build.
    logic unused_strb;
    assign unused_strb = ^gnt_w.strb;

    always_ff @(posedge clk) begin
        if (grant_valid && addr_ok(gnt_aw.addr)) begin
            mem[word_idx(gnt_aw.addr)] <= gnt_w.data;
        end
    end
`endif
endmodule
